// File: rtl/niosii_pio_pkg.sv
// Shared constants for the multi-channel control PIO: register offsets,
// edge-detect mode encodings and the address-width helper.
package niosii_pio_pkg;

  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_IN   = 3'd1;
  localparam logic [2:0] OFF_MASK = 3'd2;
  localparam logic [2:0] OFF_EDGE = 3'd3;
  localparam logic [2:0] OFF_SET  = 3'd4;
  localparam logic [2:0] OFF_CLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Word address width: channel field (at least one bit) plus 3 register bits.
  function automatic int pio_aw(input int n_ch);
    int c;
    c = $clog2(n_ch);
    return ((c < 1) ? 1 : c) + 3;
  endfunction

endpackage

// File: rtl/niosii_pio_channel.sv
// One PIO channel: output word with set/clear, interrupt mask, input
// synchroniser, edge detector and sticky edge-capture word.
module niosii_pio_channel
  import niosii_pio_pkg::*;
#(
  parameter int              DATA_W      = 32,
  parameter logic [31:0]     RESET_VALUE = '0,
  parameter int              EDGE_MODE   = EDGE_RISE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_data_i,
  input  logic              wr_mask_i,
  input  logic              wr_edge_i,
  input  logic              wr_set_i,
  input  logic              wr_clr_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [DATA_W-1:0] in_i,
  output logic [DATA_W-1:0] out_o,
  output logic [DATA_W-1:0] in_sync_o,
  output logic [DATA_W-1:0] mask_o,
  output logic [DATA_W-1:0] edge_o,
  output logic              irq_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] s1_q, s2_q, h_q;
  logic [DATA_W-1:0] det;

  // Next-state for output word, mask and capture; a new edge beats a clear.
  always_comb begin
    data_d = data_q;
    if (wr_data_i)     data_d = wd_i;
    else if (wr_set_i) data_d = data_q | wd_i;
    else if (wr_clr_i) data_d = data_q & ~wd_i;
    mask_d = wr_mask_i ? wd_i : mask_q;
    case (EDGE_MODE)
      EDGE_FALL: det = ~s2_q & h_q;
      EDGE_ANY:  det = s2_q ^ h_q;
      default:   det = s2_q & ~h_q;
    endcase
    edge_d = (edge_q & ~(wr_edge_i ? wd_i : '0)) | det;
  end

  // State registers, including the two-flop synchroniser and history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VALUE[DATA_W-1:0];
      mask_q <= '0;
      edge_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      h_q    <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      s1_q   <= in_i;
      s2_q   <= s1_q;
      h_q    <= s2_q;
    end
  end

  assign out_o     = data_q;
  assign in_sync_o = s2_q;
  assign mask_o    = mask_q;
  assign edge_o    = edge_q;
  assign irq_o     = |(edge_q & mask_q);

endmodule

// File: rtl/niosii_control_pio_bank.sv
// Multi-channel Avalon-MM control PIO: address decode, per-channel
// instances, registered read mux (latency 1) and combined interrupt.
module niosii_control_pio_bank
  import niosii_pio_pkg::*;
#(
  parameter int          N_CH        = 2,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int          EDGE_MODE   = EDGE_RISE,
  localparam int         AW          = pio_aw(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic                   read,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  input  logic [N_CH*DATA_W-1:0] in_port,
  output logic [N_CH*DATA_W-1:0] out_port,
  output logic                   irq
);

  localparam int CHW = AW - 3;

  logic [CHW-1:0] ch;
  logic [2:0]     off;
  logic           wr_en, rd_en;
  logic [31:0]    rd_d, rd_q;

  logic [N_CH-1:0][DATA_W-1:0] out_w, in_w, mask_w, edge_w;
  logic [N_CH-1:0]             irq_w;

  assign ch    = address[AW-1:3];
  assign off   = address[2:0];
  assign wr_en = chipselect && !write_n;
  assign rd_en = chipselect && read;

  // Channels beyond N_CH never match a select, so they are silently dead.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr_en && (ch == CHW'(c));
    niosii_pio_channel #(
      .DATA_W(DATA_W), .RESET_VALUE(RESET_VALUE), .EDGE_MODE(EDGE_MODE)
    ) u_ch (
      .clk       (clk),
      .rst       (reset),
      .wr_data_i (sel && off == OFF_DATA),
      .wr_mask_i (sel && off == OFF_MASK),
      .wr_edge_i (sel && off == OFF_EDGE),
      .wr_set_i  (sel && off == OFF_SET),
      .wr_clr_i  (sel && off == OFF_CLR),
      .wd_i      (writedata[DATA_W-1:0]),
      .in_i      (in_port[c*DATA_W +: DATA_W]),
      .out_o     (out_w[c]),
      .in_sync_o (in_w[c]),
      .mask_o    (mask_w[c]),
      .edge_o    (edge_w[c]),
      .irq_o     (irq_w[c])
    );
  end

  assign out_port = out_w;
  assign irq      = |irq_w;

  // Read mux: write-only, reserved and out-of-range locations read zero.
  always_comb begin
    rd_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch == CHW'(c)) begin
        case (off)
          OFF_DATA: rd_d = 32'(out_w[c]);
          OFF_IN:   rd_d = 32'(in_w[c]);
          OFF_MASK: rd_d = 32'(mask_w[c]);
          OFF_EDGE: rd_d = 32'(edge_w[c]);
          default:  rd_d = '0;
        endcase
      end
    end
  end

  // readdata holds the last read until the next read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_q <= '0;
    else if (rd_en) rd_q <= rd_d;
  end

  assign readdata = rd_q;

endmodule

// File: doc/niosii_control_pio_bank.md
# niosii_control_pio_bank

Parametrised multi-channel successor to the single-word control PIO on the Nios II Avalon-MM bus. It provides N_CH independent DATA_W-bit output words, each with atomic bit set/clear, plus a synchronised input word per channel with edge capture and a maskable, level-sensitive interrupt. The host parameter-control firmware uses it to drive and observe several parameter/address/status buses through a single slave.

## Interface
- N_CH, 2: channel count, 1..16.
- DATA_W, 32: bits per channel, 1..32; unused readdata bits read 0.
- RESET_VALUE, 0: out_port value per channel at reset.
- EDGE_MODE, 0: 0 rising, 1 falling, 2 any edge.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  AW = max(1,clog2(N_CH))+3  word address; upper bits are the channel, low 3 bits are the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read  in  1  active-high read strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data, fixed read latency 1.
- in_port  in  N_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]; asynchronous to clk.
- out_port  out  N_CH*DATA_W  channel c at [c*DATA_W +: DATA_W].
- irq  out  1  level interrupt.

## Operation
- Register offsets (low 3 address bits):
  - 0 DATA: R/W output word.
  - 1 IN: read-only synchronised input.
  - 2 MASK: R/W interrupt mask.
  - 3 EDGE: read returns the capture word; write-1-to-clear.
  - 4 SET: write-only, out |= wd.
  - 5 CLR: write-only, out &= ~wd.
  - 6, 7 reserved: read 0, writes ignored.
- Write occurs when chipselect && !write_n; read when chipselect && read. Only writedata[DATA_W-1:0] is used.
- Channel index >= N_CH (non-power-of-two N_CH): writes ignored, reads return 0.
- Input path per bit: 2-flop synchroniser s1→s2, then history register h <= s2. Edge detected when: rising s2 & ~h, falling ~s2 & h, any s2 ^ h.
- EDGE bit is set by a detected edge and held until cleared by a write-1 to EDGE. If the same cycle carries a detected edge and a clear of that bit, the edge wins and the bit stays 1.
- irq = OR over all channels of (EDGE & MASK); combinational from registers, no extra flop.
- Reset values:
  - out_port = RESET_VALUE.
  - MASK, EDGE, s1, s2, h = 0.
  - readdata = 0.
  - irq = 0.
- Because history resets to 0, an in_port bit held high through reset produces one rising capture after reset release. This is intended, and firmware clears EDGE at init.

## Timing
- Write DATA/SET/CLR sampled at edge k → out_port new value after edge k (0 cycles of added latency).
- Read address sampled at edge k → readdata valid after edge k, held until the next read. No waitrequest, and no readdatavalid is exported.
- in_port transition settled before edge k → s2 at k+1, EDGE bit and irq at k+2 (rising mode). IN register reflects the new value after k+1.
- A write to MASK or EDGE at edge k updates irq after edge k.
- Reset asserted mid-transaction aborts it immediately. readdata goes to 0, and no partial write is retained.

## Structure
- Package niosii_pio_pkg holds:
  - Offset constants OFF_DATA..OFF_CLR.
  - The EDGE_MODE encodings as localparams/enum.
  - A function for AW.
- Sub-module niosii_pio_channel holds one channel's DATA, MASK, EDGE, synchroniser and edge detect, with inputs for decoded write strobes. The top instantiates it N_CH times with a generate loop and builds the read mux, readdata register and irq OR.

## Test plan
- Reset with RESET_VALUE=32'hA5A5_0000 → out_port channel 0 = A5A50000, readdata=0, irq=0; read MASK gives 0.
- Write DATA ch1 = 0000_00F0, then SET 0000_000F, then CLR 0000_0030 → out_port ch1 = 0000_00CF; ch0 unchanged. Read DATA ch1 one cycle later returns 000000CF.
- EDGE_MODE=0: raise in_port ch0 bit 3 → EDGE ch0 = 8 two edges after s1 capture; irq stays 0. Write MASK=8 → irq=1. Write EDGE=8 → irq=0.
- Edge arriving in the same cycle as a clear of that EDGE bit → bit remains 1 and irq stays asserted.
- N_CH=3: write ch3 DATA=FFFFFFFF → no out_port change. Read ch3 DATA → 0. Read offset 6 → 0.
- Assert reset during a burst of SET writes → out_port returns to RESET_VALUE asynchronously. The first write after release takes effect normally.
